seg_bus_decoder: RTL and testbench

Recovers hex digit values from a multiplexed, active-low 7-segment display bus. This is the receive end of the segment encoding used by our hex display drivers. The block synchronizes the bus, filters glitches, and maps each segment pattern back to a nibble per digit strobe. Once every digit position has been captured, it publishes a complete multi-digit word with a one-cycle valid pulse. It sits between an external or looped-back display bus and the self-check or readback logic.

---
 rtl/seg_bus_decoder.sv | 170 +++++++++++++++++
 tb/tb_seg_bus_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_bus_decoder.sv
// Receive side of the multiplexed active-low hex display bus: synchronizes, debounces and
// decodes each strobed digit, then publishes the full word once every position has been seen.
module seg_bus_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [6:0]                i_seg_in,
  input  logic [NUM_DIGITS-1:0]     i_dig_sel,
  output logic [4*NUM_DIGITS-1:0]   o_value,
  output logic                      o_value_valid,
  output logic                      o_frame_err,
  output logic [NUM_DIGITS-1:0]     o_seen_mask
);

  typedef enum logic {
    WAIT_STABLE = 1'b0,
    CAPTURED    = 1'b1
  } state_t;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  // Exact 7-bit match; result is {valid, nibble}, invalid patterns yield nibble 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = {1'b1, 4'h0};
      7'h79:   res = {1'b1, 4'h1};
      7'h24:   res = {1'b1, 4'h2};
      7'h30:   res = {1'b1, 4'h3};
      7'h19:   res = {1'b1, 4'h4};
      7'h12:   res = {1'b1, 4'h5};
      7'h02:   res = {1'b1, 4'h6};
      7'h78:   res = {1'b1, 4'h7};
      7'h00:   res = {1'b1, 4'h8};
      7'h10:   res = {1'b1, 4'h9};
      7'h08:   res = {1'b1, 4'hA};
      7'h03:   res = {1'b1, 4'hB};
      7'h46:   res = {1'b1, 4'hC};
      7'h21:   res = {1'b1, 4'hD};
      7'h06:   res = {1'b1, 4'hE};
      7'h0E:   res = {1'b1, 4'hF};
      default: res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] d);
    logic [NUM_DIGITS-1:0] dm1;
    dm1 = d - NUM_DIGITS'(1'b1);
    return (d != {NUM_DIGITS{1'b0}}) && ((d & dm1) == {NUM_DIGITS{1'b0}});
  endfunction

  logic [6:0]              r_seg_meta, r_seg_sync;
  logic [NUM_DIGITS-1:0]   r_dig_meta, r_dig_sync;
  logic [3:0]              r_cnt;
  state_t                  r_state;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [NUM_DIGITS-1:0]   r_bad;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic                    r_valid;
  logic                    r_err;

  logic                    w_change;
  logic                    w_onehot;
  logic [4:0]              w_dec;
  logic [3:0]              w_cnt_next;
  logic                    w_capture;
  logic                    w_publish;

  // Two-flop synchronizer; idle state looks like a blanked, all-off bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg_meta <= 7'h7F;
      r_seg_sync <= 7'h7F;
      r_dig_meta <= {NUM_DIGITS{1'b0}};
      r_dig_sync <= {NUM_DIGITS{1'b0}};
    end else begin
      r_seg_meta <= i_seg_in;
      r_seg_sync <= r_seg_meta;
      r_dig_meta <= i_dig_sel;
      r_dig_sync <= r_dig_meta;
    end
  end

  // A pending change is visible one stage early, so the count always describes r_*_sync.
  assign w_change  = (r_seg_meta != r_seg_sync) || (r_dig_meta != r_dig_sync);
  assign w_onehot  = is_onehot(r_dig_sync);
  assign w_dec     = decode_seg(r_seg_sync);
  assign w_publish = &r_seen;
  assign w_capture = (r_state == WAIT_STABLE) && !w_change && w_onehot &&
                     (w_cnt_next == STABLE_MAX);

  // Stability count: reload on change, saturate at the threshold.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_change) begin
      w_cnt_next = 4'd1;
    end else if (r_cnt >= STABLE_MAX) begin
      w_cnt_next = STABLE_MAX;
    end else begin
      w_cnt_next = r_cnt + 4'd1;
    end
  end

  // Stability counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // Capture FSM plus frame assembly and publish.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= WAIT_STABLE;
      r_shadow <= {(4*NUM_DIGITS){1'b0}};
      r_seen   <= {NUM_DIGITS{1'b0}};
      r_bad    <= {NUM_DIGITS{1'b0}};
      r_value  <= {(4*NUM_DIGITS){1'b0}};
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        WAIT_STABLE: begin
          if (w_capture) begin
            r_state <= CAPTURED;
          end else begin
            r_state <= WAIT_STABLE;
          end
        end
        CAPTURED: begin
          if (w_change || !w_onehot) begin
            r_state <= WAIT_STABLE;
          end else begin
            r_state <= CAPTURED;
          end
        end
        default: r_state <= WAIT_STABLE;
      endcase

      if (w_publish) begin
        r_value <= r_shadow;
        r_err   <= |r_bad;
        r_valid <= 1'b1;
        r_seen  <= {NUM_DIGITS{1'b0}};
        r_bad   <= {NUM_DIGITS{1'b0}};
      end else if (w_capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (r_dig_sync[i]) begin
            r_shadow[4*i +: 4] <= w_dec[3:0];
            r_seen[i]          <= 1'b1;
            r_bad[i]           <= !w_dec[4];
          end
        end
      end
    end
  end

  assign o_value       = r_value;
  assign o_value_valid = r_valid;
  assign o_frame_err   = r_err;
  assign o_seen_mask   = r_seen;

endmodule

// File: tb/tb_seg_bus_decoder.sv
// Bench for seg_bus_decoder: table of whole frames with scoreboarded publishes,
// plus hand sequences for latency, glitch, blanking, overwrite and mid-frame reset.
module tb_seg_bus_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] value;
  logic        value_valid;
  logic        frame_err;
  logic [3:0]  seen_mask;

  seg_bus_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_seg_in(seg_in), .i_dig_sel(dig_sel),
    .o_value(value), .o_value_valid(value_valid), .o_frame_err(frame_err),
    .o_seen_mask(seen_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [27:0] segs;      // pattern per digit position, digit i at [7*i +: 7]
    logic [7:0]  order;     // digit index driven at step j, at [2*j +: 2]
    logic [15:0] exp_value;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [15:0] value;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t mon_e;
  int checks = 0, errors = 0, pulses = 0, pushes = 0, pulses_ref = 0;
  logic [15:0] t_ev;
  logic [27:0] t_sg;
  logic [3:0]  t_n;
  logic [7:0]  t_ord;

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] ev, input logic ee);
    sb.push_back({ev, ee});
    pushes++;
  endtask

  task automatic drive(input int idx, input logic [6:0] seg, input int hold);
    dig_sel = 4'b0001 << idx;
    seg_in  = seg;
    repeat (hold) @(negedge clk);
  endtask

  task automatic drive_raw(input logic [3:0] dig, input logic [6:0] seg, input int hold);
    dig_sel = dig;
    seg_in  = seg;
    repeat (hold) @(negedge clk);
  endtask

  task automatic apply_frame(input vec_t v);
    int idx;
    for (int j = 0; j < 4; j++) begin
      idx = int'(v.order[2*j +: 2]);
      if (j == 3) push(v.exp_value, v.exp_err);
      drive(idx, v.segs[7*idx +: 7], 10);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                              input logic [6:0] s0, input logic [7:0] ord,
                              input logic [15:0] ev, input logic ee);
    return {s3, s2, s1, s0, ord, ev, ee};
  endfunction

  // Scoreboard side: every publish must match the oldest pending frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && value_valid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got value %0h with no frame pending", value);
      end else begin
        mon_e = sb.pop_front();
        check("pub_value", {16'd0, value}, {16'd0, mon_e.value});
        check("pub_err", {31'd0, frame_err}, {31'd0, mon_e.err});
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    dig_sel = 4'b0000;
    seg_in  = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_value", {16'd0, value}, 32'd0);
    check("rst_valid", {31'd0, value_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_seen", {28'd0, seen_mask}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency of capture and publish on a 1,2,3,4 frame.
    dig_sel = 4'b0001; seg_in = 7'h79;
    repeat (4) @(negedge clk);
    check("lat_no_capture", {28'd0, seen_mask}, 32'd0);
    @(negedge clk);
    check("lat_capture", {28'd0, seen_mask}, 32'h1);
    repeat (5) @(negedge clk);
    drive(1, 7'h24, 10);
    drive(2, 7'h30, 10);
    push(16'h4321, 1'b0);
    dig_sel = 4'b1000; seg_in = 7'h19;
    repeat (5) @(negedge clk);
    check("valid_early", {31'd0, value_valid}, 32'd0);
    check("seen_full", {28'd0, seen_mask}, 32'hF);
    @(negedge clk);
    check("valid_pulse", {31'd0, value_valid}, 32'd1);
    check("seen_clear", {28'd0, seen_mask}, 32'd0);
    @(negedge clk);
    check("valid_once", {31'd0, value_valid}, 32'd0);
    repeat (7) @(negedge clk);

    // Frame table: full alphabet on every position, then invalid patterns.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) begin
        t_n = 4'((k + i) % 16);
        t_ev[4*i +: 4] = t_n;
        t_sg[7*i +: 7] = seg_lut[t_n];
      end
      t_ord = (k % 2 == 1) ? 8'h1B : ((k % 4 == 2) ? 8'h72 : 8'hE4);
      vecs.push_back({t_sg, t_ord, t_ev, 1'b0});
    end
    vecs.push_back(mk(7'h46, 7'h7F, 7'h03, 7'h08, 8'hE4, 16'hC0BA, 1'b1));
    vecs.push_back(mk(7'h30, 7'h24, 7'h79, 7'h40, 8'h1B, 16'h3210, 1'b0));
    vecs.push_back(mk(7'h0E, 7'h06, 7'h21, 7'h55, 8'h72, 16'hFED0, 1'b1));
    vecs.push_back(mk(7'h10, 7'h00, 7'h78, 7'h02, 8'hE4, 16'h9876, 1'b0));
    for (int v = 0; v < vecs.size(); v++) apply_frame(vecs[v]);

    // Glitch: a 3-cycle 8 on digit 0 after a captured 5 must not be taken.
    drive(0, 7'h12, 10);
    check("glitch_seen0", {28'd0, seen_mask}, 32'h1);
    drive(0, 7'h00, 3);
    drive(1, 7'h79, 10);
    drive(2, 7'h24, 10);
    push(16'h3215, 1'b0);
    drive(3, 7'h30, 10);

    // Blanking and multi-hot strobes hold the partial frame untouched.
    pulses_ref = pulses;
    drive(0, 7'h40, 10);
    drive(1, 7'h79, 10);
    check("blank_seen_pre", {28'd0, seen_mask}, 32'h3);
    drive_raw(4'b0011, 7'h40, 20);
    check("multihot_seen", {28'd0, seen_mask}, 32'h3);
    drive_raw(4'b0000, 7'h7F, 20);
    check("blank_seen", {28'd0, seen_mask}, 32'h3);
    check("blank_no_pulse", pulses, pulses_ref);
    drive(2, 7'h24, 10);
    push(16'h3210, 1'b0);
    drive(3, 7'h30, 10);

    // Out-of-order with overwrite of digit 1 (4 then 7).
    pulses_ref = pulses;
    drive(3, 7'h10, 10);
    drive(1, 7'h19, 10);
    check("ooo_seen", {28'd0, seen_mask}, 32'hA);
    drive(1, 7'h78, 10);
    drive(0, 7'h06, 10);
    check("ooo_no_pulse", pulses, pulses_ref);
    check("ooo_seen2", {28'd0, seen_mask}, 32'hB);
    push(16'h9D7E, 1'b0);
    drive(2, 7'h21, 10);
    check("ooo_one_pulse", pulses, pulses_ref + 1);

    // Reset in the middle of a frame discards it.
    drive(0, 7'h40, 10);
    drive(1, 7'h79, 10);
    check("mid_seen", {28'd0, seen_mask}, 32'h3);
    rst_n = 1'b0; dig_sel = 4'b0000; seg_in = 7'h7F;
    #1;
    check("mid_rst_value", {16'd0, value}, 32'd0);
    check("mid_rst_valid", {31'd0, value_valid}, 32'd0);
    check("mid_rst_err", {31'd0, frame_err}, 32'd0);
    check("mid_rst_seen", {28'd0, seen_mask}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    apply_frame(mk(7'h19, 7'h30, 7'h24, 7'h79, 8'hE4, 16'h4321, 1'b0));

    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    check("pulse_count", pulses, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
